// File: rtl/sp_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arbiter_pkg
// Description : Shared types and helpers for the single-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_arbiter_pkg;

    // Controller modes: zero-fill sequencing, then request serving
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width needed to hold a requester index; never narrower than 1 bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request found when searching upward (with wrap) from i_prio.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sp_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PRIO_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PRIO_W-1:0]  i_prio,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_found;
    int   w_idx;

    // Cyclic search from the priority pointer; the first hit wins
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_prio) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arbiter
// Description : Shares one single-port RAM between NUM_REQ requesters with
//               optional power-on zero-fill, round-robin arbitration and
//               1-cycle read-response routing back to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter
    import sp_ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int COL_WIDTH  = 1,
    parameter int DATA_WIDTH = 1,
    parameter int NUM_REQ    = 2,
    parameter bit INIT_EN    = 1'b1,
    localparam int NUM_COL   = DATA_WIDTH / COL_WIDTH
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic [NUM_REQ-1:0]            REQ_WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
    input  logic [NUM_REQ*NUM_COL-1:0]    REQ_BW,
    output logic [NUM_REQ-1:0]            RSP_VALID,
    output logic [DATA_WIDTH-1:0]         RSP_RDATA,
    output logic                          INIT_DONE,
    output logic [ADDR_WIDTH-1:0]         RAM_A,
    output logic [DATA_WIDTH-1:0]         RAM_DI,
    output logic [NUM_COL-1:0]            RAM_BW,
    output logic                          RAM_CE,
    output logic                          RAM_RDWEN,
    input  logic [DATA_WIDTH-1:0]         RAM_DO
);

    localparam int     c_PRIO_W    = idx_width(NUM_REQ);
    localparam state_t c_RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

    if (((DATA_WIDTH % COL_WIDTH) != 0) || (NUM_REQ > 8) || (NUM_REQ < 1)) begin : g_param_check
        $fatal(1, "sp_ram_arbiter: illegal parameterisation");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [c_PRIO_W-1:0]   r_prio;
    logic [c_PRIO_W-1:0]   w_prio_nxt;
    logic                  r_rd_pend;
    logic [c_PRIO_W-1:0]   r_rd_own;
    logic [NUM_REQ-1:0]    w_grant;
    logic [c_PRIO_W-1:0]   w_gidx;
    int                    w_sel;
    logic                  w_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PRIO_W  (c_PRIO_W)
    ) u_rr_arbiter (
        .i_req   (REQ_VALID),
        .i_prio  (r_prio),
        .o_grant (w_grant)
    );

    // One-hot grant to index, plus the pointer value that follows it
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = c_PRIO_W'(i);
            end
        end
        w_sel      = int'(w_gidx);
        w_prio_nxt = c_PRIO_W'((w_sel + 1) % NUM_REQ);
    end

    // Mode register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next mode and RAM-side mux; reset blanks every handshake immediately
    always_comb begin
        w_state_nxt = r_state;
        REQ_READY   = '0;
        RAM_CE      = 1'b0;
        RAM_RDWEN   = 1'b0;
        RAM_A       = '0;
        RAM_DI      = '0;
        RAM_BW      = '0;
        w_hs        = 1'b0;
        case (r_state)
            ST_INIT: begin
                RAM_CE    = 1'b1;
                RAM_RDWEN = 1'b1;
                RAM_BW    = '1;
                RAM_A     = r_cnt;
                if (r_cnt == '1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (|w_grant) begin
                    REQ_READY = w_grant;
                    RAM_CE    = 1'b1;
                    RAM_RDWEN = REQ_WE[w_sel];
                    RAM_A     = REQ_ADDR[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
                    RAM_DI    = REQ_WDATA[w_sel*DATA_WIDTH +: DATA_WIDTH];
                    RAM_BW    = REQ_BW[w_sel*NUM_COL +: NUM_COL];
                    w_hs      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_RST_STATE;
            end
        endcase
        if (RST) begin
            REQ_READY = '0;
            RAM_CE    = 1'b0;
            w_hs      = 1'b0;
        end
    end

    // Fill counter, priority pointer and read-owner tracking
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt     <= '0;
            r_prio    <= '0;
            r_rd_pend <= 1'b0;
            r_rd_own  <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_hs) begin
                r_prio <= w_prio_nxt;
            end
            r_rd_pend <= w_hs && !REQ_WE[w_sel];
            if (w_hs && !REQ_WE[w_sel]) begin
                r_rd_own <= w_gidx;
            end
        end
    end

    // Response steering: data is shared, valid goes to the recorded owner
    always_comb begin
        RSP_VALID = '0;
        if (r_rd_pend) begin
            RSP_VALID[r_rd_own] = 1'b1;
        end
        RSP_RDATA = RAM_DO;
        INIT_DONE = (r_state == ST_RUN);
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_arbiter
// Description : Self-checking bench for sp_ram_arbiter with a behavioural RAM
//               and a high-level reference model of memory and arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NR = 3;
    localparam int NC = DW / CW;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NR-1:0]     REQ_VALID = '0;
    logic [NR-1:0]     REQ_READY;
    logic [NR-1:0]     REQ_WE = '0;
    logic [NR*AW-1:0]  REQ_ADDR = '0;
    logic [NR*DW-1:0]  REQ_WDATA = '0;
    logic [NR*NC-1:0]  REQ_BW = '0;
    logic [NR-1:0]     RSP_VALID;
    logic [DW-1:0]     RSP_RDATA;
    logic              INIT_DONE;
    logic [AW-1:0]     RAM_A;
    logic [DW-1:0]     RAM_DI;
    logic [NC-1:0]     RAM_BW;
    logic              RAM_CE;
    logic              RAM_RDWEN;
    logic [DW-1:0]     RAM_DO;

    int n_checks = 0;
    int n_pass   = 0;

    sp_ram_arbiter #(
        .ADDR_WIDTH (AW),
        .COL_WIDTH  (CW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .INIT_EN    (1'b1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WE    (REQ_WE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .REQ_BW    (REQ_BW),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .INIT_DONE (INIT_DONE),
        .RAM_A     (RAM_A),
        .RAM_DI    (RAM_DI),
        .RAM_BW    (RAM_BW),
        .RAM_CE    (RAM_CE),
        .RAM_RDWEN (RAM_RDWEN),
        .RAM_DO    (RAM_DO)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port RAM with byte enables and 1-cycle read
    logic [DW-1:0] ram [2**AW];
    always @(posedge CLK) begin
        if (RAM_CE) begin
            if (RAM_RDWEN) begin
                for (int b = 0; b < NC; b++)
                    if (RAM_BW[b]) ram[RAM_A][b*CW +: CW] <= RAM_DI[b*CW +: CW];
            end else begin
                RAM_DO <= ram[RAM_A];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [2**AW];
    int            m_prio;
    bit            m_pend;
    int            m_own;
    logic [DW-1:0] m_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
        m_prio = 0;
        m_pend = 1'b0;
        m_own  = 0;
        m_data = '0;
    endtask

    // Release reset and follow the fill; abort with reset at address stop_at
    task automatic fill_seq(input int stop_at);
        REQ_VALID = '1;
        REQ_WE    = '0;
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 2**AW; c++) begin
            if (c != 0) @(negedge CLK);
            #1;
            check($sformatf("fill_a[%0d]", c), RAM_A, c);
            check($sformatf("fill_ce[%0d]", c), {RAM_CE, RAM_RDWEN}, 2'b11);
            check($sformatf("fill_bw_di[%0d]", c), {RAM_BW, RAM_DI}, {4'hF, 32'h0});
            check($sformatf("fill_ready[%0d]", c), REQ_READY, 0);
            check($sformatf("fill_done[%0d]", c), INIT_DONE, 0);
            if (c == stop_at) begin
                #1 RST = 1'b1;
                #1;
                check("rst_ready", REQ_READY, 0);
                check("rst_rsp", RSP_VALID, 0);
                check("rst_ce", RAM_CE, 0);
                check("rst_done", INIT_DONE, 0);
                return;
            end
        end
        model_reset();
    endtask

    // One RUN cycle: drive at negedge, compare against model, advance model
    task automatic do_cycle(input logic [NR-1:0] v, input logic [NR-1:0] we,
                            input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] wd,
                            input logic [NR*NC-1:0] bw,
                            output logic [NR-1:0] o_ready, output logic [NR-1:0] o_rsp,
                            output logic [DW-1:0] o_rdata);
        int g;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rsp;
        logic [AW-1:0] ga;
        @(negedge CLK);
        REQ_VALID = v; REQ_WE = we; REQ_ADDR = a; REQ_WDATA = wd; REQ_BW = bw;
        #1;
        g = -1;
        for (int k = 0; k < NR; k++)
            if (g < 0 && v[(m_prio + k) % NR]) g = (m_prio + k) % NR;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_rsp = '0;
        if (m_pend) exp_rsp[m_own] = 1'b1;
        o_ready = REQ_READY; o_rsp = RSP_VALID; o_rdata = RSP_RDATA;
        check("m_ready", REQ_READY, exp_ready);
        check("m_ce", RAM_CE, g >= 0);
        check("m_done", INIT_DONE, 1);
        check("m_rsp", RSP_VALID, exp_rsp);
        if (m_pend) check("m_rdata", RSP_RDATA, m_data);
        if (g >= 0) begin
            ga = a[g*AW +: AW];
            check("m_ram_a", RAM_A, ga);
            check("m_rdwen", RAM_RDWEN, we[g]);
            if (we[g]) check("m_wr", {RAM_BW, RAM_DI}, {bw[g*NC +: NC], wd[g*DW +: DW]});
        end
        @(posedge CLK);
        m_pend = 1'b0;
        if (g >= 0) begin
            if (we[g]) begin
                for (int b = 0; b < NC; b++)
                    if (bw[g*NC + b]) ref_mem[ga][b*CW +: CW] = wd[g*DW + b*CW +: CW];
            end else begin
                m_pend = 1'b1;
                m_own  = g;
                m_data = ref_mem[ga];
            end
            m_prio = (g + 1) % NR;
        end
    endtask

    typedef struct {
        logic [NR-1:0]    v;
        logic [NR-1:0]    we;
        logic [NR*AW-1:0] a;
        logic [NR*DW-1:0] wd;
        logic [NR*NC-1:0] bw;
        logic [NR-1:0]    exp_ready;
        logic [NR-1:0]    exp_rsp;
        logic [DW-1:0]    exp_rdata;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] r_rdy, r_rsp;
        logic [DW-1:0] r_dat;
        // Requester fields: r2 | r1 | r0
        for (int i = 0; i < 6; i++)
            tbl[i] = '{3'b111, 3'b000, {3'd2, 3'd1, 3'd5}, '0, '0,
                       3'b001 << (i % 3), (i == 0) ? 3'b000 : (3'b001 << ((i + 2) % 3)), 32'h0};
        tbl[6]  = '{3'b001, 3'b001, {3'd0, 3'd0, 3'd2}, {64'h0, 32'hAABBCCDD}, 12'h00F, 3'b001, 3'b100, 32'h0};
        tbl[7]  = '{3'b010, 3'b010, {3'd0, 3'd2, 3'd0}, {32'h0, 32'h11223344, 32'h0}, 12'h030, 3'b010, 3'b000, 32'h0};
        tbl[8]  = '{3'b100, 3'b000, {3'd2, 3'd0, 3'd0}, '0, '0, 3'b100, 3'b000, 32'h0};
        tbl[9]  = '{3'b000, 3'b000, '0, '0, '0, 3'b000, 3'b100, 32'hAABB3344};
        tbl[10] = '{3'b001, 3'b001, {3'd0, 3'd0, 3'd4}, {64'h0, 32'h44444444}, 12'h00F, 3'b001, 3'b000, 32'h0};
        tbl[11] = '{3'b100, 3'b100, {3'd6, 3'd0, 3'd0}, {32'h66666666, 64'h0}, 12'hF00, 3'b100, 3'b000, 32'h0};
        tbl[12] = '{3'b010, 3'b000, {3'd0, 3'd4, 3'd0}, '0, '0, 3'b010, 3'b000, 32'h0};
        tbl[13] = '{3'b001, 3'b000, {3'd0, 3'd0, 3'd6}, '0, '0, 3'b001, 3'b010, 32'h44444444};
        tbl[14] = '{3'b000, 3'b000, '0, '0, '0, 3'b000, 3'b001, 32'h66666666};

        // Reset state
        #1;
        check("reset_ready", REQ_READY, 0);
        check("reset_rsp", RSP_VALID, 0);
        check("reset_done", INIT_DONE, 0);
        check("reset_ce", RAM_CE, 0);
        repeat (2) @(posedge CLK);

        // Fill interrupted at address 3, then a complete fill from 0
        fill_seq(3);
        repeat (2) @(posedge CLK);
        fill_seq(2**AW);

        // Table: fairness, byte-enable merge, response routing
        for (int i = 0; i < 15; i++) begin
            do_cycle(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].bw, r_rdy, r_rsp, r_dat);
            check($sformatf("tbl_ready[%0d]", i), r_rdy, tbl[i].exp_ready);
            check($sformatf("tbl_rsp[%0d]", i), r_rsp, tbl[i].exp_rsp);
            if (tbl[i].exp_rsp != 0) check($sformatf("tbl_rdata[%0d]", i), r_dat, tbl[i].exp_rdata);
        end

        // Reset right after a read handshake drops the response
        do_cycle(3'b001, 3'b000, {3'd0, 3'd0, 3'd4}, '0, '0, r_rdy, r_rsp, r_dat);
        #1 RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("rdrst_rsp[%0d]", i), RSP_VALID, 0);
            check($sformatf("rdrst_ready[%0d]", i), REQ_READY, 0);
        end
        fill_seq(2**AW);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++)
            do_cycle(NR'($urandom_range(0, 7)), NR'($urandom_range(0, 7)), (NR*AW)'($urandom),
                     {$urandom, $urandom, $urandom}, (NR*NC)'($urandom), r_rdy, r_rsp, r_dat);
        do_cycle('0, '0, '0, '0, '0, r_rdy, r_rsp, r_dat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Controller that shares one single-port RAM (`sp_ram_model`) between `NUM_REQ` requesters. It has an optional power-on zero-fill sequencer and round-robin arbitration with a one-request-per-cycle valid/ready handshake. It tracks the 1-cycle RAM read latency so each read result is routed back to its issuing requester. It sits directly in front of the RAM instance, and the requesters (cache/buffer clients) connect only to it.

## Interface
- `ADDR_WIDTH`, 1: RAM address width; depth = 2**ADDR_WIDTH.
- `COL_WIDTH`, 1: byte-enable column width.
- `DATA_WIDTH`, 1: word width; must be divisible by `COL_WIDTH`.
- `NUM_REQ`, 2: number of requesters, 1..8.
- `INIT_EN`, 1: 1 = zero-fill the whole RAM after reset.
- Derived: `NUM_COL` = DATA_WIDTH/COL_WIDTH.
- Ports are listed as name, direction, width, meaning.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `REQ_VALID` in NUM_REQ: per-requester request valid.
- `REQ_READY` out NUM_REQ: per-requester accept; at most one bit high per cycle.
- `REQ_WE` in NUM_REQ: 1 = write, 0 = read.
- `REQ_ADDR` in NUM_REQ*ADDR_WIDTH: flattened; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `REQ_WDATA` in NUM_REQ*DATA_WIDTH: flattened write data.
- `REQ_BW` in NUM_REQ*NUM_COL: flattened byte-enables; ignored for reads.
- `RSP_VALID` out NUM_REQ: one-hot read-data-valid.
- `RSP_RDATA` out DATA_WIDTH: read data, shared by all requesters.
- `INIT_DONE` out 1: high once the controller is serving requests.
- `RAM_A` out ADDR_WIDTH: RAM address.
- `RAM_DI` out DATA_WIDTH: RAM write data.
- `RAM_BW` out NUM_COL: RAM byte-enables.
- `RAM_CE` out 1: RAM chip enable.
- `RAM_RDWEN` out 1: RAM direction; 1 = write.
- `RAM_DO` in DATA_WIDTH: RAM read data, valid the cycle after a read.

## Operation
- FSM (2 states): INIT, RUN.
  - Reset enters INIT if INIT_EN=1, otherwise RUN.
  - INIT → RUN when the init counter reaches DEPTH-1 and that write is issued.
- INIT state:
  - Each cycle: RAM_CE=1, RAM_RDWEN=1, RAM_BW all ones, RAM_DI=0, RAM_A=counter.
  - Counter starts at 0 and increments by 1 per cycle.
  - REQ_READY=0 and INIT_DONE=0 throughout.
- RUN state:
  - INIT_DONE=1.
  - Round-robin grant among the asserted REQ_VALID bits, starting the search at pointer `prio`.
  - Grant g gives REQ_READY[g]=1, combinational from REQ_VALID and `prio`.
  - RAM_CE=1; RAM_A, RAM_DI, RAM_BW and RAM_RDWEN are taken from requester g.
  - After a handshake, `prio` ← (g+1) mod NUM_REQ; with no grant, `prio` holds.
  - With no valid request: RAM_CE=0, REQ_READY all zero.
- Write: completes at the handshake edge; there is no response.
- Read: on a handshake, register `rd_pend`=1 and `rd_own`=g.
  - The next cycle: RSP_VALID[rd_own]=1 and RSP_RDATA=RAM_DO.
  - Responses cannot be back-pressured; requesters must accept them.
- Back-to-back reads from different requesters are accepted every cycle, and each response goes to its own issuer.
- RSP_RDATA is don't-care when RSP_VALID=0, but must equal RAM_DO combinationally.
- A zero REQ_BW write still handshakes and consumes the cycle.

## Timing
- Reset values:
  - REQ_READY=0 and RSP_VALID=0 (REQ_READY is also forced 0 while RST is high).
  - INIT_DONE = !INIT_EN.
  - `prio`=0, counter=0, `rd_pend`=0.
  - RAM_CE=0 while RST is asserted.
- Read latency: handshake at edge N gives RSP_VALID high in the cycle after edge N. That is exactly 1 cycle, and RSP_VALID is registered.
- Throughput: 1 request per cycle. Zero-fill takes exactly DEPTH cycles; INIT_DONE rises in the cycle after the last fill write.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately.
  - A pending read response is dropped.
  - The fill restarts from address 0.
- A request held valid without ready must keep its fields stable; the arbiter does not latch them.

## Structure
- Package `sp_ram_arbiter_pkg`: state enum (INIT, RUN) and a `clog2`-based width helper for `prio`/`rd_own`.
- Sub-module `rr_arbiter`: parameter NUM_REQ; inputs req vector and `prio`; output one-hot grant. Purely combinational.
- The top level holds the FSM, init counter, `prio` register, read-tracking registers and the RAM-side mux.
- Elaboration check: `$fatal` if DATA_WIDTH % COL_WIDTH ≠ 0 or NUM_REQ > 8.

## Test plan
- **Zero-fill:** INIT_EN=1, ADDR_WIDTH=3, release reset → 8 fill writes to A=0..7, then INIT_DONE=1 in cycle 9, with no REQ_READY before that. A subsequent read of A=5 returns 0.
- **Fairness:** NUM_REQ=3, all REQ_VALID held high → grants 0,1,2,0,1,2 on consecutive cycles.
- **Byte-enable merge:** DATA_WIDTH=32, COL_WIDTH=8. Requester 0 writes 0xAABBCCDD to A=2 with BW=4'b1111. Requester 1 then writes 0x11223344 to A=2 with BW=4'b0011. A read of A=2 returns 0xAABB3344.
- **Response routing:** requester 1 reads A=4 and requester 0 reads A=6 in back-to-back cycles → RSP_VALID=2'b10 carrying mem[4], then RSP_VALID=2'b01 carrying mem[6].
- **Reset mid-fill:** assert RST at fill address 3 → REQ_READY=0 and RSP_VALID=0 immediately; after release the fill restarts at A=0.
- **Reset mid-read:** a read handshake followed by RST in the same cycle as the response → RSP_VALID never asserts.
